// File: rtl/sram_like_pkg.sv
// sram_like_pkg: size codes, LFSR seed and lane/alignment helpers shared by the
// sram-like bus master (datapath) and responder.
package sram_like_pkg;

    localparam logic [1:0]  SIZE_BYTE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd1;
    localparam logic [1:0]  SIZE_WORD = 2'd2;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Reserved size 3 behaves as a word access.
    function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SIZE_BYTE) ? 4'b0001 << addr_lo :
               (size == SIZE_HALF) ? 4'b0011 << addr_lo : 4'b1111;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SIZE_HALF) ? addr_lo[0] : (size != SIZE_BYTE) && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/sram_like_responder_sp_ram_be.sv
// sp_ram_be: single-port sync RAM, 32-bit words, per-byte write enables, registered read
module sp_ram_be #(
  parameter int ADDR_WIDTH = 16,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++)
        if (i_we && i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      o_rdata <= r_mem[i_addr];
    end
  end
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of the sram-like bus, backed by a byte-writable
// RAM and answering every accepted request in order after exactly LATENCY cycles.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2,
    parameter bit STALL_EN   = 1'b0,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        misalign_err
);

    logic               r_ready;
    logic               r_err;
    logic [15:0]        r_lfsr;
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_wr;
    logic               w_stall;
    logic               w_accept;
    logic               w_mis;
    logic               w_fb;
    logic               w_unused;
    logic [31:0]        w_data [LATENCY];

    assign w_stall  = STALL_EN && (r_lfsr[1:0] == 2'b00);
    assign addr_ok  = r_ready && !w_stall;
    assign w_accept = req && addr_ok;
    assign w_mis    = is_misaligned(size, addr[1:0]);
    assign w_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_unused = ^addr[31:ADDR_WIDTH+2];

    // Misaligned writes are answered but change no bytes.
    sp_ram_be #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk    (clk),
        .i_en   (w_accept),
        .i_we   (wr && !w_mis),
        .i_be   (be_from_size(size, addr[1:0])),
        .i_addr (addr[ADDR_WIDTH+1:2]),
        .i_wdata(wdata),
        .o_rdata(w_data[0])
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ready <= 1'b0;
            r_lfsr  <= LFSR_SEED;
            r_err   <= 1'b0;
            r_vld   <= '0;
            r_wr    <= '0;
        end else begin
            r_ready <= 1'b1;
            r_lfsr  <= {w_fb, r_lfsr[15:1]};
            r_err   <= r_err || (w_accept && w_mis);
            r_vld   <= (r_vld << 1) | LATENCY'(w_accept);
            r_wr    <= (r_wr << 1) | LATENCY'(wr);
        end
    end

    // The RAM output register is stage 0; data stages need no reset as valid qualifies them.
    for (genvar s = 1; s < LATENCY; s++) begin : g_stage
        logic [31:0] r_data;
        always_ff @(posedge clk) r_data <= w_data[s-1];
        assign w_data[s] = r_data;
    end

    assign data_ok      = r_vld[LATENCY-1];
    assign rdata        = (data_ok && !r_wr[LATENCY-1]) ? w_data[LATENCY-1] : 32'h0;
    assign misalign_err = r_err;

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: two responders (no stall / LFSR stall) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_sram_like_responder;

    localparam int AW  = 12;
    localparam int LAT = 2;

    typedef struct {
        int          due;
        bit          w;
        bit          k;
        logic [31:0] d;
    } resp_t;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic [1:0]       req, wr, addr_ok, data_ok, misalign_err;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] addr, wdata, rdata;

    resp_t       q [2][$];
    logic [31:0] mem [int];
    logic [15:0] m_lfsr [2];
    bit          m_rdy [2];
    bit          m_err [2];
    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_acc1 = 0;
    int          n_dok1 = 0;

    always #5 clk = ~clk;

    sram_like_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .STALL_EN(1'b0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rstn(rstn), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
        .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]),
        .misalign_err(misalign_err[0])
    );

    sram_like_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .STALL_EN(1'b1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rstn(rstn), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
        .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]),
        .misalign_err(misalign_err[1])
    );

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
        end
    endtask

    function automatic void accept(input int i);
        int    idx = int'(addr[i][AW+1:2]);
        int    key = (i << 20) | idx;
        int    lo  = int'(addr[i][1:0]);
        int    nb  = 0;
        bit    mis = (size[i] == 2'd1 && addr[i][0]) || (size[i] >= 2'd2 && lo != 0);
        resp_t r;
        r.due = cyc + LAT;
        r.w   = wr[i];
        r.k   = mem.exists(key);
        r.d   = r.k ? mem[key] : 32'h0;
        if (wr[i] && !mis) begin
            logic [31:0] v = r.d;
            for (int b = 0; b < 4; b++) begin
                if (size[i] == 2'd0 ? b == lo : size[i] == 2'd1 ? (b / 2) == (lo / 2) : 1'b1) begin
                    v[8*b +: 8] = wdata[i][8*b +: 8];
                    nb++;
                end
            end
            if (nb == 4 || r.k) mem[key] = v;
        end
        if (mis) m_err[i] = 1'b1;
        q[i].push_back(r);
        if (i == 1) n_acc1++;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            resp_t r;
            bit    aok;
            bit    eok;
            if (!rstn) begin
                q[i].delete();
                m_rdy[i]  = 1'b0;
                m_err[i]  = 1'b0;
                m_lfsr[i] = 16'hACE1;
            end
            aok = m_rdy[i] && !(i == 1 && m_lfsr[i] % 4 == 0);
            eok = q[i].size() > 0 && q[i][0].due == cyc;
            chk("addr_ok", i, 32'(addr_ok[i]), 32'(aok));
            chk("data_ok", i, 32'(data_ok[i]), 32'(eok));
            chk("misalign_err", i, 32'(misalign_err[i]), 32'(m_err[i]));
            if (eok) begin
                r = q[i].pop_front();
                if (r.w || r.k) chk("rdata", i, rdata[i], r.w ? 32'h0 : r.d);
            end else begin
                chk("rdata_idle", i, rdata[i], 32'h0);
            end
            if (i == 1 && data_ok[1]) n_dok1++;
            if (rstn) begin
                if (req[i] && aok) accept(i);
                m_rdy[i]  = 1'b1;
                m_lfsr[i] = (m_lfsr[i] >> 1) |
                            16'((m_lfsr[i][0] ^ m_lfsr[i][2] ^ m_lfsr[i][3] ^ m_lfsr[i][5]) * 32768);
            end
        end
        cyc++;
    end

    task automatic issue(input int i, input bit w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        req[i] = 1'b1; wr[i] = w; size[i] = sz; addr[i] = a; wdata[i] = d;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = addr_ok[i];
            @(posedge clk);
            #1;
        end
        req[i] = 1'b0;
        chk("accept_within_bound", i, 32'(ok), 32'h1);
    endtask

    task automatic resp(input int i, input string name, input logic [31:0] e);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = data_ok[i];
        end
        chk({name, "_latency"}, i, 32'(n), 32'(LAT));
        chk(name, i, rdata[i], e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
        req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("addr_ok_before_first_edge", 0, 32'(addr_ok[0]), 32'h0);
        chk("data_ok_in_reset", 0, 32'(data_ok[0]), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("addr_ok_after_release", 0, 32'(addr_ok[0]), 32'h1);
        @(posedge clk);
        #1;

        issue(0, 1'b1, 2'd2, 32'h1000, 32'hDEADBEEF);
        resp(0, "word_write_resp", 32'h0);
        issue(0, 1'b0, 2'd2, 32'h1000, 32'h0);
        resp(0, "word_read", 32'hDEADBEEF);

        issue(0, 1'b1, 2'd2, 32'h1000, 32'h11223344);
        resp(0, "word_write2_resp", 32'h0);
        issue(0, 1'b1, 2'd0, 32'h1002, 32'h00AA0000);
        resp(0, "byte_write_resp", 32'h0);
        issue(0, 1'b0, 2'd2, 32'h1000, 32'h0);
        resp(0, "byte_merge_read", 32'h11AA3344);
        issue(0, 1'b1, 2'd1, 32'h1000, 32'h00005566);
        resp(0, "half_write_resp", 32'h0);
        issue(0, 1'b0, 2'd2, 32'h1000, 32'h0);
        resp(0, "half_merge_read", 32'h11AA5566);

        chk("misalign_clear", 0, 32'(misalign_err[0]), 32'h0);
        issue(0, 1'b1, 2'd2, 32'h1001, 32'hFFFFFFFF);
        resp(0, "misaligned_write_resp", 32'h0);
        chk("misalign_set", 0, 32'(misalign_err[0]), 32'h1);
        issue(0, 1'b0, 2'd1, 32'h1003, 32'h0);
        resp(0, "misaligned_read_aligned_word", 32'h11AA5566);
        chk("misalign_sticky", 0, 32'(misalign_err[0]), 32'h1);

        issue(0, 1'b1, 2'd2, 32'h2000, 32'hCAFEF00D);
        resp(0, "pre_reset_write_resp", 32'h0);
        issue(0, 1'b0, 2'd2, 32'h2000, 32'h0);
        issue(0, 1'b0, 2'd2, 32'h2004, 32'h0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("no_data_ok_after_reset", 0, 32'(data_ok[0]), 32'h0);
            @(posedge clk);
            #1;
        end
        chk("misalign_cleared_by_reset", 0, 32'(misalign_err[0]), 32'h0);
        issue(0, 1'b0, 2'd2, 32'h2000, 32'h0);
        resp(0, "write_survives_reset", 32'hCAFEF00D);

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) begin
                issue(i, 1'b1, 2'd2, (i == 1 ? 32'h3000 : 32'h1000) + 32'(k * 4), $urandom);
                resp(i, "preload_resp", 32'h0);
            end

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                req[i]   = $urandom_range(0, 99) < 70;
                wr[i]    = 1'($urandom);
                size[i]  = 2'($urandom);
                addr[i]  = (i == 1 ? 32'h3000 : 32'h1000) + 32'($urandom_range(0, 7) * 4) +
                           32'($urandom_range(0, 3)) + 32'($urandom_range(0, 3) << 18);
                wdata[i] = $urandom;
            end
            @(posedge clk);
            #1;
        end
        req = '0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("stall_data_ok_count", 1, 32'(n_dok1), 32'(n_acc1));
        chk("stall_accepts_seen", 1, 32'(n_acc1 > 40), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

endmodule
